// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - imem request/response and decode handshake bundle for fetch_queue
interface fetch_queue_if;
    // Execute-stage redirect
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    // Instruction-memory request/response channel
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    // Decode-stage handshake
    logic        dec_valid_o;
    logic [31:0] dec_instr_o;
    logic [31:0] dec_pc_o;
    logic [31:0] dec_pc4_o;
    logic        dec_ready_i;

    // Fetch queue side
    modport master (
        input  redirect_i,
        input  redirect_pc_i,
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        output dec_valid_o,
        output dec_instr_o,
        output dec_pc_o,
        output dec_pc4_o,
        input  dec_ready_i
    );

    // Memory / decode / execute side
    modport slave (
        output redirect_i,
        output redirect_pc_i,
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i,
        input  dec_valid_o,
        input  dec_instr_o,
        input  dec_pc_o,
        input  dec_pc4_o,
        output dec_ready_i
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue between imem port and decode; optional same-cycle bypass under FETCH_BYPASS_EN
module fetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
    // Wide enough to hold count + outstanding without wrapping
    localparam int unsigned SW = CW + OW;

    // Queue storage: PC and instruction word per entry
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [OW-1:0] out_q, out_d;
    logic [OW-1:0] drop_q, drop_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;

    logic          rsp_live;
    logic          rsp_drop;
    logic          rsp_keep;
    logic          q_nonempty;
    logic          byp_hit;
    logic          byp_take;
    logic          dec_valid;
    logic          push;
    logic          pop;
    logic          issue;
    logic          fire;
    logic [SW-1:0] inflight;
    logic [31:0]   head_pc;
    logic [31:0]   head_instr;

    // Classify the incoming response: responses with nothing outstanding belong
    // to requests abandoned by reset; stale ones after a redirect are dropped.
    always_comb begin
        rsp_live   = bus.imem_rvalid_i && (out_q != '0);
        rsp_drop   = rsp_live && (drop_q != '0);
        rsp_keep   = rsp_live && (drop_q == '0);
        q_nonempty = (count_q != '0);
`ifdef FETCH_BYPASS_EN
        byp_hit    = rsp_keep && !q_nonempty && !bus.redirect_i && !rst;
`else
        byp_hit    = 1'b0;
`endif
    end

    // Decode-side head presentation and handshake; data reads zero when not valid
    always_comb begin
        dec_valid  = !rst && (q_nonempty || byp_hit);
        head_pc    = q_nonempty ? pc_mem_q[head_q]    : resp_pc_q;
        head_instr = q_nonempty ? instr_mem_q[head_q] : bus.imem_rdata_i;

        bus.dec_valid_o = dec_valid;
        bus.dec_pc_o    = dec_valid ? head_pc          : 32'h0;
        bus.dec_instr_o = dec_valid ? head_instr       : 32'h0;
        bus.dec_pc4_o   = dec_valid ? head_pc + 32'd4  : 32'h0;

        pop      = dec_valid && bus.dec_ready_i && q_nonempty;
        byp_take = byp_hit && bus.dec_ready_i;
        push     = rsp_keep && !byp_take;
    end

    // Request issue: reserve a queue slot for every live in-flight request so a
    // returning word can always be pushed; stale requests need no slot.
    always_comb begin
        inflight = SW'(count_q) + SW'(out_q) - SW'(drop_q);
        issue    = !rst && !bus.redirect_i
                   && (inflight < SW'(DEPTH))
                   && (out_q < OW'(MAX_OUTSTANDING));
        fire     = issue && bus.imem_gnt_i;

        bus.imem_req_o  = issue;
        bus.imem_addr_o = fetch_pc_q;
    end

    // Next-state: redirect flushes the queue and marks every remaining
    // in-flight response stale; otherwise normal push/pop/issue bookkeeping.
    always_comb begin
        out_d = out_q + OW'(fire) - OW'(rsp_live);
        if (bus.redirect_i) begin
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            fetch_pc_d = bus.redirect_pc_i & 32'hFFFF_FFFC;
            resp_pc_d  = bus.redirect_pc_i & 32'hFFFF_FFFC;
            drop_d     = out_d;
        end else begin
            count_d    = count_q + CW'(push) - CW'(pop);
            head_d     = head_q + PW'(pop);
            tail_d     = tail_q + PW'(push);
            fetch_pc_d = fire     ? fetch_pc_q + 32'd4 : fetch_pc_q;
            resp_pc_d  = rsp_keep ? resp_pc_q + 32'd4  : resp_pc_q;
            drop_d     = drop_q - OW'(rsp_drop);
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
        end
    end

    // Queue storage write at the tail; contents need no reset since count gates them
    always_ff @(posedge clk) begin
        if (push && !bus.redirect_i && !rst) begin
            pc_mem_q[tail_q]    <= resp_pc_q;
            instr_mem_q[tail_q] <= bus.imem_rdata_i;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard testbench for fetch_queue
module tb_fetch_queue;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk;
    logic rst;
    logic rsp_en;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_seg    = 0;
    logic [31:0] hold_addr;
    logic [31:0] exp_q  [$];
    logic [31:0] pend_q [$];

    fetch_queue_if bus ();

    fetch_queue #(
        .DEPTH           (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: record granted addresses, answer in order one cycle later
    initial begin
        forever begin
            @(negedge clk);
            if (bus.imem_req_o && bus.imem_gnt_i) pend_q.push_back(bus.imem_addr_o);
        end
    end

    initial begin
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (rsp_en && pend_q.size() > 0) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = mem_word(pend_q.pop_front());
            end else begin
                bus.imem_rvalid_i = 1'b0;
                bus.imem_rdata_i  = 32'h0;
            end
        end
    end

    // Monitor: every word decode accepts must match the scoreboard head
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && !bus.redirect_i && bus.dec_valid_o && bus.dec_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got pc %h, expected no word", bus.dec_pc_o);
                end else begin
                    e = exp_q.pop_front();
                    check("dec_pc", bus.dec_pc_o, e);
                    check("dec_instr", bus.dec_instr_o, mem_word(e));
                    check("dec_pc4", bus.dec_pc4_o, e + 32'd4);
                    n_seg++;
                end
            end
        end
    end

    // Watchdog
    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected stimulus completion");
        $fatal(1, "watchdog expired");
    end

    task automatic load_exp(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(i * 4));
        n_seg = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(bus.imem_req_o),  32'h0);
        check({tag, "_valid"}, 32'(bus.dec_valid_o), 32'h0);
        check({tag, "_instr"}, bus.dec_instr_o,      32'h0);
        check({tag, "_pc"},    bus.dec_pc_o,         32'h0);
        check({tag, "_pc4"},   bus.dec_pc4_o,        32'h0);
    endtask

    initial begin
        rst               = 1'b1;
        rsp_en            = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.imem_gnt_i    = 1'b1;
        bus.dec_ready_i   = 1'b1;

        // Reset state
        tick();
        @(negedge clk);
        check_reset_outputs("reset");

        // Free-running fetch from RESET_PC
        tick();
        rst = 1'b0;
        load_exp(32'h0);
        @(negedge clk);
        check("first_req", 32'(bus.imem_req_o), 32'h1);
        check("first_addr", bus.imem_addr_o, 32'h0);
        @(negedge clk);
        check("lat_cycle1_valid", 32'(bus.dec_valid_o), (LAT == 1) ? 32'h1 : 32'h0);
        @(negedge clk);
        check("lat_cycle2_valid", 32'(bus.dec_valid_o), 32'h1);
        repeat (6) begin
            @(negedge clk);
            check("stream_valid", 32'(bus.dec_valid_o), 32'h1);
        end

        // Decode stall fills the queue to DEPTH
        tick();
        bus.dec_ready_i = 1'b0;
        repeat (10) @(negedge clk);
        check("stall_req", 32'(bus.imem_req_o), 32'h0);
        check("stall_valid", 32'(bus.dec_valid_o), 32'h1);

        // Release with grants withheld: exactly four words drain
        tick();
        bus.imem_gnt_i  = 1'b0;
        bus.dec_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_valid", 32'(bus.dec_valid_o), 32'h1);
        end
        @(negedge clk);
        check("drain_empty", 32'(bus.dec_valid_o), 32'h0);

        // Address held stable while request is not granted
        hold_addr = 32'(n_seg * 4);
        repeat (5) begin
            check("hold_req", 32'(bus.imem_req_o), 32'h1);
            check("hold_addr", bus.imem_addr_o, hold_addr);
            @(negedge clk);
        end
        tick();
        bus.imem_gnt_i = 1'b1;
        @(negedge clk);
        tick();
        bus.imem_gnt_i = 1'b0;
        @(negedge clk);
        check("step_addr", bus.imem_addr_o, hold_addr + 32'd4);
        tick();
        bus.imem_gnt_i = 1'b1;

        // Redirect with two responses in flight
        tick();
        rsp_en = 1'b0;
        repeat (4) @(negedge clk);
        check("max_out_req", 32'(bus.imem_req_o), 32'h0);
        check("max_out_valid", 32'(bus.dec_valid_o), 32'h0);
        tick();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0100;
        load_exp(32'h0000_0100);
        @(negedge clk);
        check("redir_req", 32'(bus.imem_req_o), 32'h0);
        tick();
        bus.redirect_i = 1'b0;
        rsp_en         = 1'b1;
        repeat (8) @(negedge clk);
        tick();
        check("redir_words", 32'(n_seg), 32'(7 - LAT));

        // Reset with two responses in flight and words queued
        bus.dec_ready_i = 1'b0;
        rsp_en          = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_req", 32'(bus.imem_req_o), 32'h0);
        tick();
        rst            = 1'b1;
        bus.imem_gnt_i = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        tick();
        rst             = 1'b0;
        rsp_en          = 1'b1;
        bus.dec_ready_i = 1'b1;
        load_exp(32'h0);
        repeat (3) begin
            @(negedge clk);
            check("late_rvalid_valid", 32'(bus.dec_valid_o), 32'h0);
            check("restart_req", 32'(bus.imem_req_o), 32'h1);
            check("restart_addr", bus.imem_addr_o, 32'h0);
        end
        tick();
        bus.imem_gnt_i = 1'b1;
        repeat (8) @(negedge clk);
        tick();
        check("restart_words", 32'(n_seg), 32'(8 - LAT));

`ifdef FETCH_BYPASS_EN
        // Same-cycle bypass into an empty queue
        bus.imem_gnt_i = 1'b0;
        repeat (4) @(negedge clk);
        tick();
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0020;
        load_exp(32'h0000_0020);
        @(negedge clk);
        tick();
        bus.redirect_i = 1'b0;
        bus.imem_gnt_i = 1'b1;
        @(negedge clk);
        tick();
        bus.imem_gnt_i = 1'b0;
        @(negedge clk);
        check("bypass_valid", 32'(bus.dec_valid_o), 32'h1);
        check("bypass_pc", bus.dec_pc_o, 32'h0000_0020);
        tick();
        @(negedge clk);
        check("bypass_no_push", 32'(bus.dec_valid_o), 32'h0);
        tick();
        check("bypass_words", 32'(n_seg), 32'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
